nor_gate: RTL and testbench
===========================

NOR_GATE -- requirements
Module: nor_gate

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the bit width of din_a, din_b, dout and dout_q.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the saturating high-cycle counter.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock for all registered logic.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port din_a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port din_b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port dout, output, WIDTH bits: combinational bitwise NOR of din_a and din_b.
REQ-009 The block SHALL have port dout_q, output, WIDTH bits: dout registered once on clk.
REQ-010 The block SHALL have port dout_rise, output, WIDTH bits: one-cycle per-bit rising-edge pulse of dout_q.
REQ-011 The block SHALL have port dout_fall, output, WIDTH bits: one-cycle per-bit falling-edge pulse of dout_q.
REQ-012 The block SHALL have port hi_cnt, output, CNT_W bits: count of clk cycles in which dout bit 0 was 1, saturating.
REQ-013 The block SHALL have port hi_cnt_sat, output, 1 bit: high while hi_cnt equals its all-ones maximum.

Function
REQ-014 dout SHALL equal ~(din_a | din_b) per bit, with zero clock latency, independent of clk and rst.
REQ-015 dout SHALL settle in the same delta as the input change, so a clockless bench sees it immediately.
REQ-016 Truth table per bit: 00->1, 01->0, 10->0, 11->0.
REQ-017 dout_q SHALL capture dout on each rising clk edge while rst is low: latency 1 cycle.
REQ-018 dout_rise[i] SHALL be 1 for exactly the cycle after dout_q[i] goes 0->1, and 0 otherwise.
REQ-019 dout_fall[i] SHALL be 1 for exactly the cycle after dout_q[i] goes 1->0, and 0 otherwise.
REQ-020 Edge detection SHALL compare dout_q against an internal one-cycle-delayed copy of dout_q, registered from the same clk.
REQ-021 hi_cnt SHALL increment by 1 on each rising edge where dout[0] is 1 and hi_cnt is below its maximum.
REQ-022 At the maximum value, hi_cnt SHALL hold and SHALL NOT wrap to 0.
REQ-023 hi_cnt_sat SHALL be combinational from hi_cnt.
REQ-024 Inputs changing between clock edges SHALL affect only dout; registered outputs SHALL sample only at the rising edge.
REQ-025 X or Z on the inputs SHALL NOT be masked; dout follows standard Verilog NOR semantics.

Reset
REQ-026 While rst is high at a rising edge, the following SHALL all be cleared to 0: dout_q, the delayed copy, dout_rise, dout_fall and hi_cnt.
REQ-027 The first rising edge after rst deasserts SHALL load dout_q from dout.
REQ-028 No edge pulse SHALL fire on the first cycle after reset unless dout_q goes 0->1.
REQ-029 dout SHALL remain functional during reset.
REQ-030 Reset asserted mid-count SHALL clear hi_cnt on that edge, with priority over increment.

Verification
REQ-031 Clockless sweep, WIDTH=1, 10 ns steps, (a,b) = 00, 01, 10, 11: dout SHALL read 1, 0, 0, 0 immediately after each step.
REQ-032 Hold (a,b)=00 for 3 cycles after reset: dout_q=1 after edge 1; dout_rise=1 only on edge 2; hi_cnt=3.
REQ-033 Change (a,b) from 00 to 01 with dout_q=1: dout_q=0 one edge later; dout_fall pulses for one cycle.
REQ-034 CNT_W=4, hold dout=1 for 20 cycles: hi_cnt saturates at 15; hi_cnt_sat=1; no wrap.
REQ-035 Assert rst for 1 cycle while hi_cnt=7 and dout=1: hi_cnt=0 and dout_q=0 after that edge, while dout stays 1.
REQ-036 WIDTH=4, a=4'b0101, b=4'b0011: dout SHALL read 4'b1000.

Source files
------------

// File: rtl/nor_gate.sv
// Bitwise NOR with a registered copy, per-bit edge pulses and a saturating
// counter of cycles in which bit 0 of the NOR result is high.
module nor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_q,
  output logic [WIDTH-1:0] dout_rise,
  output logic [WIDTH-1:0] dout_fall,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             hi_cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] hi_cnt_d;

  // Continuous assignment keeps X/Z propagation identical to a plain NOR.
  assign dout = ~(din_a | din_b);

  // Edges are judged between out_q and its one-cycle-delayed copy, so each
  // pulse appears one cycle after out_q itself changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      dly_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      out_q  <= dout;
      dly_q  <= out_q;
      rise_q <= out_q & ~dly_q;
      fall_q <= ~out_q & dly_q;
    end
  end

  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if ((dout[0] == 1'b1) && (hi_cnt_q != CNT_MAX)) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
    end
  end

  assign dout_q     = out_q;
  assign dout_rise  = rise_q;
  assign dout_fall  = fall_q;
  assign hi_cnt     = hi_cnt_q;
  assign hi_cnt_sat = (hi_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_nor_gate.sv
// Scoreboard bench for nor_gate: the driver queues hand-computed expectations,
// a monitor process pops and compares them against three DUT configurations.
module tb_nor_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u1: WIDTH=1 CNT_W=16, u4: WIDTH=1 CNT_W=4, uw: WIDTH=4 CNT_W=8
  logic        rst1, rst4, rstw;
  logic        a1, b1, a4, b4;
  logic [3:0]  aw, bw;
  logic        d1, q1, r1, f1, s1;
  logic [15:0] h1;
  logic        d4, q4, r4, f4, s4;
  logic [3:0]  h4;
  logic [3:0]  dw, qw, rw, fw;
  logic [7:0]  hw;
  logic        sw;

  nor_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst1), .din_a(a1), .din_b(b1), .dout(d1), .dout_q(q1),
    .dout_rise(r1), .dout_fall(f1), .hi_cnt(h1), .hi_cnt_sat(s1));

  nor_gate #(.WIDTH(1), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst4), .din_a(a4), .din_b(b4), .dout(d4), .dout_q(q4),
    .dout_rise(r4), .dout_fall(f4), .hi_cnt(h4), .hi_cnt_sat(s4));

  nor_gate #(.WIDTH(4), .CNT_W(8)) uw (
    .clk(clk), .rst(rstw), .din_a(aw), .din_b(bw), .dout(dw), .dout_q(qw),
    .dout_rise(rw), .dout_fall(fw), .hi_cnt(hw), .hi_cnt_sat(sw));

  typedef struct packed {
    logic [7:0]  sel;
    logic [15:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    pushed = 0;
  int    popped = 0;
  int    n_vec  = 0;
  int    n_err  = 0;
  bit    drv_done = 1'b0;

  function automatic logic [15:0] probe(input logic [7:0] sel);
    case (sel)
      8'd0:  probe = {15'd0, d1};
      8'd1:  probe = {15'd0, q1};
      8'd2:  probe = {15'd0, r1};
      8'd3:  probe = {15'd0, f1};
      8'd4:  probe = h1;
      8'd5:  probe = {15'd0, s1};
      8'd6:  probe = {12'd0, h4};
      8'd7:  probe = {15'd0, s4};
      8'd8:  probe = {15'd0, q4};
      8'd9:  probe = {12'd0, dw};
      8'd10: probe = {12'd0, qw};
      8'd11: probe = {12'd0, rw};
      8'd12: probe = {12'd0, fw};
      default: probe = 16'hxxxx;
    endcase
  endfunction

  task automatic expect_val(input logic [7:0] sel, input logic [15:0] v, input string nm);
    exp_t e;
    e.sel = sel;
    e.val = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
    pushed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation at the moment it is posted.
  initial begin
    exp_t        e;
    string       nm;
    logic [15:0] act;
    forever begin
      wait (pushed > popped);
      while (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        popped++;
        act = probe(e.sel);
        n_vec++;
        if (act !== e.val) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, act, e.val);
        end else begin
          $display("ok   %s: %h", nm, act);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] sweep_ab [4];
    logic       sweep_y  [4];
    sweep_ab[0] = 2'b00; sweep_y[0] = 1'b1;
    sweep_ab[1] = 2'b01; sweep_y[1] = 1'b0;
    sweep_ab[2] = 2'b10; sweep_y[2] = 1'b0;
    sweep_ab[3] = 2'b11; sweep_y[3] = 1'b0;

    rst1 = 1'b1; rst4 = 1'b1; rstw = 1'b1;
    a1 = 1'b0; b1 = 1'b0; a4 = 1'b0; b4 = 1'b0; aw = 4'd0; bw = 4'd0;
    #1;

    // Combinational sweep while reset is held.
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = sweep_ab[i];
      #1;
      expect_val(8'd0, {15'd0, sweep_y[i]}, $sformatf("sweep_ab%b", sweep_ab[i]));
      #9;
    end

    tick();
    tick();
    expect_val(8'd1, 16'd0, "rst_dout_q");
    expect_val(8'd2, 16'd0, "rst_rise");
    expect_val(8'd3, 16'd0, "rst_fall");
    expect_val(8'd4, 16'd0, "rst_hi_cnt");
    expect_val(8'd6, 16'd0, "rst_hi_cnt_w4");
    expect_val(8'd10, 16'd0, "rst_dout_q_w4bit");

    // Hold 00 for three edges after reset.
    a1 = 1'b0; b1 = 1'b0; rst1 = 1'b0;
    tick();
    expect_val(8'd1, 16'd1, "e1_dout_q");
    expect_val(8'd2, 16'd0, "e1_rise");
    expect_val(8'd4, 16'd1, "e1_hi_cnt");
    tick();
    expect_val(8'd2, 16'd1, "e2_rise");
    expect_val(8'd4, 16'd2, "e2_hi_cnt");
    tick();
    expect_val(8'd2, 16'd0, "e3_rise");
    expect_val(8'd4, 16'd3, "e3_hi_cnt");

    // 00 -> 01: dout drops immediately, dout_q next edge, fall pulse after.
    b1 = 1'b1;
    #1;
    expect_val(8'd0, 16'd0, "ab01_dout");
    tick();
    expect_val(8'd1, 16'd0, "e4_dout_q");
    expect_val(8'd3, 16'd0, "e4_fall");
    expect_val(8'd4, 16'd3, "e4_hi_cnt_hold");
    tick();
    expect_val(8'd3, 16'd1, "e5_fall");
    tick();
    expect_val(8'd3, 16'd0, "e6_fall");
    expect_val(8'd2, 16'd0, "e6_rise");

    // Count up to 7, then a one-cycle reset with dout still 1.
    b1 = 1'b0;
    repeat (4) tick();
    expect_val(8'd4, 16'd7, "pre_rst_hi_cnt");
    rst1 = 1'b1;
    tick();
    expect_val(8'd4, 16'd0, "mid_rst_hi_cnt");
    expect_val(8'd1, 16'd0, "mid_rst_dout_q");
    expect_val(8'd0, 16'd1, "mid_rst_dout");
    rst1 = 1'b0;
    tick();
    expect_val(8'd1, 16'd1, "post_rst_dout_q");
    expect_val(8'd4, 16'd1, "post_rst_hi_cnt");
    expect_val(8'd2, 16'd0, "post_rst_rise");
    expect_val(8'd3, 16'd0, "post_rst_fall");
    tick();
    expect_val(8'd2, 16'd1, "post_rst_rise2");

    // Saturation with a 4-bit counter.
    rst4 = 1'b0;
    repeat (14) tick();
    expect_val(8'd6, 16'd14, "sat_cnt14");
    expect_val(8'd7, 16'd0, "sat_flag14");
    tick();
    expect_val(8'd6, 16'd15, "sat_cnt15");
    expect_val(8'd7, 16'd1, "sat_flag15");
    repeat (5) tick();
    expect_val(8'd6, 16'd15, "sat_cnt20");
    expect_val(8'd7, 16'd1, "sat_flag20");
    expect_val(8'd8, 16'd1, "sat_dout_q");

    // 4-bit wide vector and per-bit edges.
    aw = 4'b0101; bw = 4'b0011;
    #1;
    expect_val(8'd9, 16'h0008, "w4_dout");
    rstw = 1'b0;
    tick();
    expect_val(8'd10, 16'h0008, "w4_dout_q");
    expect_val(8'd11, 16'h0000, "w4_e1_rise");
    tick();
    expect_val(8'd11, 16'h0008, "w4_e2_rise");
    expect_val(8'd12, 16'h0000, "w4_e2_fall");
    aw = 4'b1000; bw = 4'b0000;
    #1;
    expect_val(8'd9, 16'h0007, "w4_dout2");
    tick();
    expect_val(8'd10, 16'h0007, "w4_e3_dout_q");
    expect_val(8'd11, 16'h0000, "w4_e3_rise");
    expect_val(8'd12, 16'h0000, "w4_e3_fall");
    tick();
    expect_val(8'd11, 16'h0007, "w4_e4_rise");
    expect_val(8'd12, 16'h0008, "w4_e4_fall");
    tick();
    expect_val(8'd11, 16'h0000, "w4_e5_rise");
    expect_val(8'd12, 16'h0000, "w4_e5_fall");

    drv_done = 1'b1;
  end

  initial begin
    wait (drv_done);
    repeat (5) @(posedge clk);
    if (popped != pushed) begin
      n_err++;
      $display("FAIL drain: popped %0d expected %0d", popped, pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
